// File: rtl/mips_pkg.sv
// Shared MIPS core constants: widths, ALU op codes, I-type opcodes and ALU class encodings.
package mips_pkg;

    localparam int unsigned BitsSize  = 32;
    localparam int unsigned BitsShamt = 5;
    localparam int unsigned BitsOp    = 6;
    localparam int unsigned BitsReg   = 5;

    // ALU op codes share the R-type funct encoding so class 10 can pass funct straight through
    localparam logic [BitsOp-1:0] AluOpAdd = 6'b100000;
    localparam logic [BitsOp-1:0] AluOpSub = 6'b100010;
    localparam logic [BitsOp-1:0] AluOpAnd = 6'b100100;
    localparam logic [BitsOp-1:0] AluOpOr  = 6'b100101;
    localparam logic [BitsOp-1:0] AluOpXor = 6'b100110;
    localparam logic [BitsOp-1:0] AluOpNor = 6'b100111;
    localparam logic [BitsOp-1:0] AluOpSlt = 6'b101010;
    localparam logic [BitsOp-1:0] AluOpSll = 6'b000000;
    localparam logic [BitsOp-1:0] AluOpSrl = 6'b000010;
    localparam logic [BitsOp-1:0] AluOpSra = 6'b000011;

    localparam logic [BitsOp-1:0] OpAndi = 6'b001100;
    localparam logic [BitsOp-1:0] OpOri  = 6'b001101;
    localparam logic [BitsOp-1:0] OpXori = 6'b001110;
    localparam logic [BitsOp-1:0] OpSlti = 6'b001010;

    typedef enum logic [1:0] {
        AluClassAdd   = 2'b00,
        AluClassSub   = 2'b01,
        AluClassRtype = 2'b10,
        AluClassItype = 2'b11
    } alu_class_e;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-control decode: ALU class plus funct/opcode to ALU op and shift-amount select.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0]        alu_class_i,
    input  logic [BitsOp-1:0] funct_i,
    input  logic [BitsOp-1:0] opcode_i,
    output logic [BitsOp-1:0] alu_op_o,
    output logic              flag_shamt_o
);

    alu_class_e alu_class;
    assign alu_class = alu_class_e'(alu_class_i);

    always_comb begin
        alu_op_o     = AluOpAdd;
        flag_shamt_o = 1'b0;
        unique case (alu_class)
            AluClassAdd: alu_op_o = AluOpAdd;
            AluClassSub: alu_op_o = AluOpSub;
            AluClassRtype: begin
                alu_op_o     = funct_i;
                // Only the constant-shift forms take the shift amount from instr[10:6]
                flag_shamt_o = (funct_i == AluOpSll) || (funct_i == AluOpSrl) ||
                               (funct_i == AluOpSra);
            end
            AluClassItype: begin
                unique case (opcode_i)
                    OpAndi:  alu_op_o = AluOpAnd;
                    OpOri:   alu_op_o = AluOpOr;
                    OpXori:  alu_op_o = AluOpXor;
                    OpSlti:  alu_op_o = AluOpSlt;
                    default: alu_op_o = AluOpAdd;
                endcase
            end
            default: alu_op_o = AluOpAdd;
        endcase
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with registered ALU-control decode, stall/flush/step gating and
// a sticky halt flag that suppresses architectural writes after HALT.
module id_ex_register
    import mips_pkg::*;
#(
    parameter int unsigned BITS_SIZE  = 32,
    parameter int unsigned BITS_SHAMT = 5,
    parameter int unsigned BITS_OP    = 6,
    parameter int unsigned BITS_REG   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [BITS_SIZE-1:0]  i_pc4,
    input  logic [BITS_SIZE-1:0]  i_data_a,
    input  logic [BITS_SIZE-1:0]  i_data_b,
    input  logic [BITS_SIZE-1:0]  i_imm,
    input  logic [BITS_SHAMT-1:0] i_shamt,
    input  logic [BITS_OP-1:0]    i_funct,
    input  logic [BITS_OP-1:0]    i_opcode,
    input  logic [BITS_REG-1:0]   i_rs,
    input  logic [BITS_REG-1:0]   i_rt,
    input  logic [BITS_REG-1:0]   i_rd,
    input  logic [1:0]            i_alu_class,
    input  logic                  i_alu_src,
    input  logic                  i_reg_dst,
    input  logic                  i_reg_write,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_halt,
    output logic [BITS_SIZE-1:0]  o_pc4,
    output logic [BITS_SIZE-1:0]  o_data_a,
    output logic [BITS_SIZE-1:0]  o_data_b,
    output logic [BITS_SIZE-1:0]  o_imm,
    output logic [BITS_SHAMT-1:0] o_shamt,
    output logic [BITS_REG-1:0]   o_rs,
    output logic [BITS_REG-1:0]   o_rt,
    output logic [BITS_REG-1:0]   o_rd,
    output logic [BITS_OP-1:0]    o_alu_op,
    output logic                  o_flag_shamt,
    output logic                  o_alu_src,
    output logic                  o_reg_dst,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_valid,
    output logic                  o_halt
);

    typedef struct packed {
        logic [BITS_SIZE-1:0]  pc4;
        logic [BITS_SIZE-1:0]  data_a;
        logic [BITS_SIZE-1:0]  data_b;
        logic [BITS_SIZE-1:0]  imm;
        logic [BITS_SHAMT-1:0] shamt;
        logic [BITS_REG-1:0]   rs;
        logic [BITS_REG-1:0]   rt;
        logic [BITS_REG-1:0]   rd;
        logic [BITS_OP-1:0]    alu_op;
        logic                  flag_shamt;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  valid;
    } id_ex_t;

    id_ex_t id_ex_d, id_ex_q;
    logic   halt_d, halt_q;

    logic [BITS_OP-1:0] dec_alu_op;
    logic               dec_flag_shamt;

    alu_control u_alu_control (
        .alu_class_i  (i_alu_class),
        .funct_i      (i_funct),
        .opcode_i     (i_opcode),
        .alu_op_o     (dec_alu_op),
        .flag_shamt_o (dec_flag_shamt)
    );

    always_comb begin
        id_ex_d = id_ex_q;
        halt_d  = halt_q;
        if (i_flush) begin
            id_ex_d        = '0;
            id_ex_d.alu_op = AluOpAdd;
        end else if (i_enable && !i_stall) begin
            id_ex_d.pc4        = i_pc4;
            id_ex_d.data_a     = i_data_a;
            id_ex_d.data_b     = i_data_b;
            id_ex_d.imm        = i_imm;
            id_ex_d.shamt      = i_shamt;
            id_ex_d.rs         = i_rs;
            id_ex_d.rt         = i_rt;
            id_ex_d.rd         = i_rd;
            id_ex_d.alu_op     = dec_alu_op;
            id_ex_d.flag_shamt = dec_flag_shamt;
            id_ex_d.alu_src    = i_alu_src;
            id_ex_d.reg_dst    = i_reg_dst;
            id_ex_d.mem_to_reg = i_mem_to_reg;
            id_ex_d.valid      = i_valid;
            // Bubbles and anything past a halt must not touch registers or memory
            id_ex_d.reg_write  = i_reg_write && i_valid && !halt_q;
            id_ex_d.mem_write  = i_mem_write && i_valid && !halt_q;
            id_ex_d.mem_read   = i_mem_read && i_valid;
            halt_d             = halt_q || (i_halt && i_valid);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            id_ex_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            id_ex_q <= id_ex_d;
            halt_q  <= halt_d;
        end
    end

    assign o_pc4        = id_ex_q.pc4;
    assign o_data_a     = id_ex_q.data_a;
    assign o_data_b     = id_ex_q.data_b;
    assign o_imm        = id_ex_q.imm;
    assign o_shamt      = id_ex_q.shamt;
    assign o_rs         = id_ex_q.rs;
    assign o_rt         = id_ex_q.rt;
    assign o_rd         = id_ex_q.rd;
    assign o_alu_op     = id_ex_q.alu_op;
    assign o_flag_shamt = id_ex_q.flag_shamt;
    assign o_alu_src    = id_ex_q.alu_src;
    assign o_reg_dst    = id_ex_q.reg_dst;
    assign o_reg_write  = id_ex_q.reg_write;
    assign o_mem_read   = id_ex_q.mem_read;
    assign o_mem_write  = id_ex_q.mem_write;
    assign o_mem_to_reg = id_ex_q.mem_to_reg;
    assign o_valid      = id_ex_q.valid;
    assign o_halt       = halt_q;

endmodule
